// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NREQ requesters,
// holding each grant for bursts of up to MAX_BURST accepted words.
module fifo_wr_arbiter #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned NREQ      = 4,
    parameter int unsigned IDX_WIDTH = 2,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATAWIDTH-1:0] req_data,
    output logic [NREQ-1:0]           gnt,
    output logic                      fifo_wr,
    output logic [DATAWIDTH-1:0]      fifo_din,
    input  logic                      fifo_full,
    output logic [IDX_WIDTH-1:0]      owner,
    output logic                      busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t               state, state_nxt;
    logic [IDX_WIDTH-1:0] owner_nxt;
    logic [CNT_WIDTH-1:0] burst_cnt, cnt_nxt;
    logic [IDX_WIDTH-1:0] pick;
    logic                 pick_vld;
    logic                 own_req;
    logic                 accept;
    logic                 burst_done;

    // Search owner+1 .. owner+NREQ (mod NREQ): the current owner comes last,
    // which also covers the "exclude owner when its burst is done" handoff.
    always_comb begin
        logic [IDX_WIDTH-1:0] cand;
        pick     = owner;
        pick_vld = 1'b0;
        cand     = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDX_WIDTH'((32'(owner) + k) % NREQ);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick     = cand;
            end
        end
    end

    assign busy       = (state == GRANT);
    assign own_req    = req[owner];
    // rstn gates the strobe so a burst caught by reset writes nothing on that edge
    assign accept     = busy & own_req & ~fifo_full & rstn;
    assign burst_done = (burst_cnt == CNT_WIDTH'(MAX_BURST - 1));
    assign fifo_wr    = accept;

    always_comb begin
        gnt      = '0;
        fifo_din = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (accept && owner == IDX_WIDTH'(i)) begin
                gnt[i]   = 1'b1;
                fifo_din = req_data[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cnt_nxt   = burst_cnt;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = GRANT;
                    owner_nxt = pick;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (!own_req || (accept && burst_done)) begin
                    if (pick_vld) begin
                        owner_nxt = pick;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (accept) begin
                    cnt_nxt = burst_cnt + CNT_WIDTH'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            owner     <= IDX_WIDTH'(NREQ - 1);
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            burst_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random bench for fifo_wr_arbiter against a depth-4 fifo model
// with a per-requester scoreboard.
module tb_fifo_wr_arbiter;

    localparam int unsigned DW    = 8;
    localparam int unsigned NR    = 4;
    localparam int unsigned IW    = 2;
    localparam int unsigned MB    = 4;
    localparam int unsigned CW    = 2;
    localparam int unsigned DEPTH = 4;

    logic              clk  = 1'b0;
    logic              rstn = 1'b0;
    logic [NR-1:0]     req  = '0;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     gnt;
    logic              fifo_wr;
    logic [DW-1:0]     fifo_din;
    logic              fifo_full;
    logic [IW-1:0]     owner;
    logic              busy;

    logic [DW-1:0]     data_r [NR];
    logic              rd = 1'b0;
    logic [NR-1:0]     g_last = '0;
    logic [DW+IW-1:0]  fq [$];
    logic [DW-1:0]     exp_q [NR][$];
    int                fcount = 0;
    int                wait_cnt [NR];
    int                n_total = 0;
    int                n_pass  = 0;

    always #5 clk = ~clk;

    assign req_data  = {data_r[3], data_r[2], data_r[1], data_r[0]};
    assign fifo_full = (fcount == DEPTH);

    fifo_wr_arbiter #(
        .DATAWIDTH(DW),
        .NREQ     (NR),
        .IDX_WIDTH(IW),
        .MAX_BURST(MB),
        .CNT_WIDTH(CW)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .fifo_wr  (fifo_wr),
        .fifo_din (fifo_din),
        .fifo_full(fifo_full),
        .owner    (owner),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // fifo model: pop before push, writes ignored while full
    always @(posedge clk) begin
        logic [DW+IW-1:0] e;
        logic [IW-1:0]    id;
        if (rd && fq.size() > 0) begin
            e  = fq.pop_front();
            id = e[DW+IW-1:DW];
            check("sb_pending", exp_q[id].size() != 0, 1);
            if (exp_q[id].size() != 0) check("sb_order", e[DW-1:0], exp_q[id].pop_front());
        end
        if (fifo_wr && !fifo_full) begin
            id = '0;
            for (int i = 0; i < NR; i++) if (gnt[i]) id = IW'(i);
            fq.push_back({id, fifo_din});
        end
        fcount <= fq.size();
    end

    always @(negedge clk) begin
        check("gnt_onehot", $onehot0(gnt), 1);
        check("wr_when_full", fifo_wr & fifo_full, 0);
        check("wr_vs_gnt", fifo_wr, |gnt);
        for (int i = 0; i < NR; i++) begin
            if (gnt[i]) begin
                check("din", fifo_din, data_r[i]);
                exp_q[i].push_back(data_r[i]);
            end
            if (!req[i] || gnt[i]) begin
                wait_cnt[i] <= 0;
            end else if (fifo_wr) begin
                wait_cnt[i] <= wait_cnt[i] + 1;
                check("starve", (wait_cnt[i] + 1) <= 3*MB, 1);
            end
        end
    end

    task automatic sample();
        @(negedge clk);
    endtask

    // Advance each requester's data word after it has been granted.
    task automatic step();
        g_last = gnt;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (g_last[i]) data_r[i] = data_r[i] + 8'd1;
    endtask

    task automatic reset_dut();
        rstn = 1'b0;
        req  = '0;
        repeat (2) begin sample(); step(); end
        rstn = 1'b1;
    endtask

    task automatic drain();
        req = '0;
        rd  = 1'b1;
        repeat (8) begin sample(); step(); end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            data_r[i]   = 8'(i * 64);
            wait_cnt[i] = 0;
        end

        // reset state
        reset_dut();
        sample();
        check("rst_busy", busy, 0);
        check("rst_gnt", gnt, 0);
        check("rst_wr", fifo_wr, 0);
        check("rst_din", fifo_din, 0);
        check("rst_owner", owner, 3);
        step();

        // single requester, 6 words: burst of 4 then re-grant with no bubble
        data_r[0] = 8'h10;
        rd  = 1'b1;
        req = 4'b0001;
        sample();
        check("t1_lat_gnt", gnt, 0);
        check("t1_lat_busy", busy, 0);
        step();
        for (int c = 0; c < 6; c++) begin
            sample();
            check("t1_gnt", gnt, 4'b0001);
            check("t1_din", fifo_din, 8'h10 + c);
            check("t1_owner", owner, 0);
            step();
        end
        req = '0;
        sample();
        check("t1_rel_busy", busy, 1);
        check("t1_rel_gnt", gnt, 0);
        step();
        sample();
        check("t1_idle_busy", busy, 0);
        step();
        drain();
        check("t1_all_out", exp_q[0].size(), 0);

        // all requesting: 0,1,2,3,0 in bursts of 4
        reset_dut();
        rd  = 1'b1;
        req = 4'b1111;
        sample();
        check("t2_idle_gnt", gnt, 0);
        step();
        for (int b = 0; b < 20; b++) begin
            sample();
            check("t2_gnt", gnt, 1 << ((b / 4) % 4));
            check("t2_owner", owner, (b / 4) % 4);
            step();
        end
        drain();

        // fifo fills: grant frozen while full, resumes on a read
        reset_dut();
        rd  = 1'b0;
        req = 4'b0101;
        sample(); step();
        for (int w = 0; w < 4; w++) begin
            sample();
            check("t3_fill_gnt", gnt, 4'b0001);
            step();
        end
        for (int c = 0; c < 3; c++) begin
            if (c == 2) rd = 1'b1;
            sample();
            check("t3_full_gnt", gnt, 0);
            check("t3_full_wr", fifo_wr, 0);
            check("t3_full_owner", owner, 2);
            check("t3_full_busy", busy, 1);
            step();
        end
        for (int w = 0; w < 4; w++) begin
            sample();
            check("t3_resume_gnt", gnt, 4'b0100);
            check("t3_resume_owner", owner, 2);
            step();
        end
        sample();
        check("t3_next_gnt", gnt, 4'b0001);
        check("t3_next_owner", owner, 0);
        step();
        drain();

        // req1 released after 2 words while req3 pending
        reset_dut();
        rd  = 1'b1;
        req = 4'b1010;
        sample(); step();
        for (int w = 0; w < 2; w++) begin
            sample();
            check("t4_gnt1", gnt, 4'b0010);
            check("t4_owner1", owner, 1);
            step();
        end
        req = 4'b1000;
        sample();
        check("t4_rel_gnt", gnt, 0);
        check("t4_rel_owner", owner, 1);
        step();
        for (int w = 0; w < 4; w++) begin
            sample();
            check("t4_gnt3", gnt, 4'b1000);
            check("t4_owner3", owner, 3);
            step();
            req = 4'b1010;
        end
        sample();
        check("t4_back_gnt", gnt, 4'b0010);
        check("t4_back_owner", owner, 1);
        step();
        drain();

        // reset mid-burst (owner 2, two words taken)
        reset_dut();
        rd  = 1'b1;
        req = 4'b0100;
        sample(); step();
        for (int w = 0; w < 2; w++) begin
            sample();
            check("t5_gnt2", gnt, 4'b0100);
            step();
        end
        rstn = 1'b0;
        sample(); step();
        rstn = 1'b1;
        req  = 4'b1111;
        sample();
        check("t5_rst_gnt", gnt, 0);
        check("t5_rst_wr", fifo_wr, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_owner", owner, 3);
        check("t5_rst_din", fifo_din, 0);
        step();
        sample();
        check("t5_first_gnt", gnt, 4'b0001);
        check("t5_first_owner", owner, 0);
        step();
        drain();

        // random req / fifo reads
        reset_dut();
        g_last = '0;
        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (g_last[i])   req[i] = ($urandom_range(0, 1) == 1);
                else if (req[i]) begin
                    if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
                end else         req[i] = ($urandom_range(0, 1) == 1);
            end
            rd = ($urandom_range(0, 2) != 0);
            sample();
            step();
        end
        drain();
        for (int i = 0; i < NR; i++) check("rnd_no_loss", exp_q[i].size(), 0);
        check("rnd_fifo_empty", fq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
